phys_free_list: RTL



---
 rtl/phys_free_list_if.sv | 27 ++
 rtl/phys_free_list.sv | 119 +++++++++++
 2 files changed

// File: rtl/phys_free_list_if.sv
// Rename/commit/flush port bundle for the physical-register free list.
// master = rename/ROB/flush side, slave = the free list itself.
interface phys_free_list_if #(
  parameter int PHYS_W = 6,
  parameter int CNT_W  = 6
);
  logic              alloc_req;
  logic              alloc_gnt;
  logic [PHYS_W-1:0] alloc_phys;
  logic              commit_en;
  logic              free_en;
  logic [PHYS_W-1:0] free_phys;
  logic              flush;
  logic [CNT_W-1:0]  free_count;
  logic              empty;
  logic              err;

  modport master (
    output alloc_req, commit_en, free_en, free_phys, flush,
    input  alloc_gnt, alloc_phys, free_count, empty, err
  );

  modport slave (
    input  alloc_req, commit_en, free_en, free_phys, flush,
    output alloc_gnt, alloc_phys, free_count, empty, err
  );
endinterface

// File: rtl/phys_free_list.sv
// Free list of physical IDs: circular FIFO with speculative and committed heads; 0-cycle grant, no grant when empty or flushing.
// Flush restores spec head to commit head in one cycle. FREE_LIST_CHECK_EN adds a double-free bitmap and a sticky err flag.
module phys_free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int PHYS_W        = $clog2(NUM_PHYS_REGS)
) (
  input logic             clk,
  input logic             rst,
  phys_free_list_if.slave fl
);
  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [PHYS_W-1:0] phys_t;

  ptr_t  spec_head_q, spec_head_d;
  ptr_t  commit_head_q, commit_head_d;
  ptr_t  tail_q, tail_d;
  phys_t fifo_q [DEPTH];
  phys_t fifo_d [DEPTH];

  ptr_t  free_count;
  logic  empty;
  logic  alloc_gnt;
  logic  commit_bad;
  logic  overflow;
  logic  dbl_free;
  logic  free_ok;

  always_comb begin
    free_count    = tail_q - spec_head_q;
    empty         = (free_count == '0);
    alloc_gnt     = fl.alloc_req & ~empty & ~fl.flush;
    commit_bad    = (commit_head_q == spec_head_q);
    // Occupancy counted from the committed head: uncommitted IDs still hold their slots.
    overflow      = ((tail_q - commit_head_q) == ptr_t'(DEPTH));
    free_ok       = fl.free_en & ~overflow & ~dbl_free;

    commit_head_d = commit_head_q + ptr_t'(fl.commit_en & ~commit_bad);
    spec_head_d   = fl.flush ? commit_head_d : (spec_head_q + ptr_t'(alloc_gnt));
    tail_d        = tail_q + ptr_t'(free_ok);

    fifo_d = fifo_q;
    if (free_ok) begin
      fifo_d[tail_q[IDX_W-1:0]] = fl.free_phys;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= ptr_t'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= phys_t'(NUM_ARCH_REGS + i);
      end
    end else begin
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      fifo_q        <= fifo_d;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PHYS_REGS-1:0] is_free_q, is_free_d;
  logic                     err_q, err_d;
  ptr_t                     span;

  assign dbl_free = is_free_q[fl.free_phys];

  always_comb begin
    is_free_d = is_free_q;
    span      = spec_head_q - commit_head_d;
    if (alloc_gnt) begin
      is_free_d[fifo_q[spec_head_q[IDX_W-1:0]]] = 1'b0;
    end
    // Squashed IDs sit between the post-commit head and the old speculative head.
    if (fl.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ptr_t'(i) < span) begin
          is_free_d[fifo_q[IDX_W'(commit_head_d + ptr_t'(i))]] = 1'b1;
        end
      end
    end
    if (free_ok) begin
      is_free_d[fl.free_phys] = 1'b1;
    end
    err_d = err_q
          | (fl.commit_en & commit_bad)
          | (fl.free_en & (overflow | dbl_free));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        is_free_q[i] <= (i >= NUM_ARCH_REGS);
      end
    end else begin
      err_q     <= err_d;
      is_free_q <= is_free_d;
    end
  end

  assign fl.err = err_q;
`else
  assign dbl_free = 1'b0;
  assign fl.err   = 1'b0;
`endif

  assign fl.alloc_gnt  = alloc_gnt;
  assign fl.alloc_phys = fifo_q[spec_head_q[IDX_W-1:0]];
  assign fl.free_count = free_count;
  assign fl.empty      = empty;
endmodule
